// File: rtl/dmem_ctrl_if.sv
// Request/response bundle between a load/store unit (master) and dmem_ctrl (slave).
interface dmem_ctrl_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_ctrl.sv
// Byte-addressed data memory with one outstanding request, programmable read latency and
// range/size/alignment errors. Define DMEM_MISALIGN_TRAP_EN to trap misaligned accesses.
module dmem_ctrl #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned RD_LAT      = 1
) (
  input  logic        clk,
  input  logic        rst,
  dmem_ctrl_if.slave  bus,
  output logic        busy
);
  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(NB);
  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH_WORDS);

  typedef enum logic [1:0] {StIdle, StRwait, StResp} state_e;

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q;
  logic [OFF_W-1:0]  off_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic              err_q;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  logic              accept, mis_err, range_err, size_err, req_err, wr_en;
  logic [ADDR_W-1:0] size_mask, eff_addr, word_addr;
  logic [IDX_W-1:0]  req_idx, rd_idx;
  logic [OFF_W-1:0]  req_off, rd_off;
  logic [1:0]        rd_size;
  logic              rd_uns, rd_err, rd_we, to_resp;
  logic [NB-1:0]     be;
  logic [DATA_W-1:0] wdata_sh, load_data;

  // Shift the addressed lanes down to bit 0, then sign- or zero-extend.
  function automatic logic [DATA_W-1:0] extend_load(input logic [DATA_W-1:0] word,
                                                    input logic [OFF_W-1:0]  off,
                                                    input logic [1:0]        size,
                                                    input logic              uns);
    logic [DATA_W-1:0] sh;
    logic [DATA_W-1:0] keep;
    int                nbits;
    sh    = word >> {off, 3'b000};
    nbits = 8 << size;
    if (nbits > int'(DATA_W)) nbits = int'(DATA_W);
    keep = '1;
    if (nbits < int'(DATA_W)) keep = (DATA_W'(1) << nbits) - DATA_W'(1);
    sh = sh & keep;
    if (!uns && sh[nbits-1]) sh = sh | ~keep;
    return sh;
  endfunction

  assign accept = bus.req_valid && bus.req_ready;

  always_comb begin
    size_mask = (ADDR_W'(1) << bus.req_size) - ADDR_W'(1);
`ifdef DMEM_MISALIGN_TRAP_EN
    mis_err   = |(bus.req_addr & size_mask);
    eff_addr  = bus.req_addr;
`else
    mis_err   = 1'b0;
    eff_addr  = bus.req_addr & ~size_mask;
`endif
    word_addr = eff_addr >> OFF_W;
    range_err = word_addr >= DEPTH_A;
    size_err  = (DATA_W == 32) && (bus.req_size == 2'd3);
    req_err   = range_err || size_err || mis_err;
    req_idx   = word_addr[IDX_W-1:0];
    req_off   = eff_addr[OFF_W-1:0];
  end

  always_comb begin
    int nbytes;
    nbytes   = 1 << bus.req_size;
    wr_en    = accept && bus.req_we && !req_err;
    wdata_sh = bus.req_wdata << {req_off, 3'b000};
    for (int i = 0; i < int'(NB); i++) begin
      be[i] = (i >= int'(req_off)) && (i < int'(req_off) + nbytes);
    end
  end

  // Stores commit on the accept edge; RAM is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < int'(NB); i++) begin
        if (be[i]) mem[req_idx][8*i +: 8] <= wdata_sh[8*i +: 8];
      end
    end
  end

  // With RD_LAT=1 the read happens in the accept cycle, so bypass the latched fields.
  always_comb begin
    if (state_q == StIdle) begin
      rd_idx  = req_idx;
      rd_off  = req_off;
      rd_size = bus.req_size;
      rd_uns  = bus.req_unsigned;
      rd_err  = req_err;
      rd_we   = bus.req_we;
    end else begin
      rd_idx  = idx_q;
      rd_off  = off_q;
      rd_size = size_q;
      rd_uns  = uns_q;
      rd_err  = err_q;
      rd_we   = 1'b0;
    end
    load_data = extend_load(mem[rd_idx], rd_off, rd_size, rd_uns);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    to_resp = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (bus.req_we || RD_LAT <= 1) begin
            state_d = StResp;
            to_resp = 1'b1;
          end else begin
            state_d = StRwait;
            cnt_d   = 2'(RD_LAT - 1);
          end
        end
      end
      StRwait: begin
        if (cnt_q <= 2'd1) begin
          state_d = StResp;
          to_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      StResp: begin
        if (bus.rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (to_resp) rdata_d = (rd_err || rd_we) ? '0 : load_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      off_q   <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      if (accept) begin
        idx_q  <= req_idx;
        off_q  <= req_off;
        size_q <= bus.req_size;
        uns_q  <= bus.req_unsigned;
        err_q  <= req_err;
      end
    end
  end

  assign bus.req_ready = (state_q == StIdle);
  assign bus.rsp_valid = (state_q == StResp);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: directed cases plus random traffic against a byte-array model.
module tb_dmem_ctrl;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 64;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned RD_LAT = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic busy;
  int   cyc = 0;
  int   nchecks = 0;
  int   nerrors = 0;
  bit   hold = 1'b0;
  bit   mon_en = 1'b0;

  dmem_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  dmem_ctrl #(
    .DATA_W     (DATA_W),
    .DEPTH_WORDS(DEPTH),
    .ADDR_W     (ADDR_W),
    .RD_LAT     (RD_LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
    int          lat;
    bit          seen;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] ref_mem [4*DEPTH];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference behaviour straight from the access rules, on a flat byte array.
  function automatic void model(input logic we, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                output logic [31:0] rdata, output logic err);
    int              nb;
    longint          a;
    bit [63:0]       v;
    nb    = 1 << size;
    a     = longint'(addr);
    err   = 1'b0;
    rdata = '0;
    if (size == 2'd3) err = 1'b1;
`ifdef DMEM_MISALIGN_TRAP_EN
    if (a % nb != 0) err = 1'b1;
`else
    a = a - (a % nb);
`endif
    if (a / 4 >= longint'(DEPTH)) err = 1'b1;
    if (!err) begin
      if (we) begin
        for (int k = 0; k < nb; k++) ref_mem[a+k] = wdata[8*k +: 8];
      end else begin
        v = '0;
        for (int k = 0; k < nb; k++) v = v | (64'(ref_mem[a+k]) << (8*k));
        if (!uns && v[8*nb-1]) v = v | ~((64'd1 << (8*nb)) - 64'd1);
        rdata = v[31:0];
      end
    end
  endfunction

  // rsp_ready changes just after the edge so the monitor samples it stable.
  initial bus.rsp_ready = 1'b0;
  always @(posedge clk) begin
    #1;
    bus.rsp_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  always @(negedge clk) begin
    if (mon_en && bus.rsp_valid) begin
      chk("req_ready_in_resp", {63'd0, bus.req_ready}, 64'd0);
      chk("busy_in_resp", {63'd0, busy}, 64'd1);
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", 64'd1, 64'd0);
      end else begin
        if (!exp_q[0].seen) begin
          chk("rsp_latency", 64'(cyc - exp_q[0].acc), 64'(exp_q[0].lat));
          exp_q[0].seen = 1'b1;
        end
        chk("rsp_rdata", {32'd0, bus.rsp_rdata}, {32'd0, exp_q[0].rdata});
        chk("rsp_err", {63'd0, bus.rsp_err}, {63'd0, exp_q[0].err});
        if (bus.rsp_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
    int          n;
    exp_t        e;
    logic [31:0] rd;
    logic        er;
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    n = 0;
    while (!bus.req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      chk("accept_timeout", 64'd1, 64'd0);
      bus.req_valid = 1'b0;
    end else begin
      model(we, size, uns, addr, wdata, rd, er);
      e.rdata = rd;
      e.err   = er;
      e.acc   = cyc;
      e.lat   = we ? 1 : int'(RD_LAT);
      e.seen  = 1'b0;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'd0;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", {63'd0, bus.req_ready}, 64'd1);
    chk("rst_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
    chk("rst_rsp_rdata", {32'd0, bus.rsp_rdata}, 64'd0);
    chk("rst_rsp_err", {63'd0, bus.rsp_err}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    rst    = 1'b1;
    mon_en = 1'b1;

    for (int i = 0; i < int'(DEPTH); i++) do_req(1'b1, 2'd2, 1'b0, 32'(4*i), $urandom);

    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    do_req(1'b1, 2'd0, 1'b0, 32'h13, 32'h0000_0080);
    do_req(1'b0, 2'd0, 1'b0, 32'h13, 32'h0);
    do_req(1'b0, 2'd0, 1'b1, 32'h13, 32'h0);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    do_req(1'b0, 2'd1, 1'b0, 32'h11, 32'h0);
    do_req(1'b1, 2'd2, 1'b0, 32'(4*DEPTH), 32'h1234_5678);
    do_req(1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
    do_req(1'b0, 2'd3, 1'b0, 32'h8, 32'h0);
    wait_drain();

    // Response held off: a competing request must not be taken.
    hold = 1'b1;
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    n = 0;
    while (!bus.rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("hold_rsp_arrives", {63'd0, bus.rsp_valid}, 64'd1);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_size  = 2'd2;
    bus.req_addr  = 32'h10;
    bus.req_wdata = 32'h1234_5678;
    repeat (5) begin
      @(negedge clk);
      chk("hold_rsp_valid", {63'd0, bus.rsp_valid}, 64'd1);
      chk("hold_req_ready", {63'd0, bus.req_ready}, 64'd0);
    end
    bus.req_valid = 1'b0;
    hold = 1'b0;
    wait_drain();
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    wait_drain();

    // Reset while the load sits in the wait state.
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    @(negedge clk);
    mon_en = 1'b0;
    rst    = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("midrst_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_req_ready", {63'd0, bus.req_ready}, 64'd1);
    rst    = 1'b1;
    mon_en = 1'b1;
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    do_req(1'b0, 2'd0, 1'b1, 32'h13, 32'h0);
    wait_drain();

    for (int i = 0; i < 300; i++) begin
      do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             32'($urandom_range(0, 4*DEPTH + 15)), $urandom);
    end
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", nchecks, nerrors);
    $finish;
  end
endmodule
